// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the RV32I integer core: steps each instruction
// through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It drives the memory
// handshakes, the datapath load strobes, the ALU op and the regfile write.
module multicycle_controller #(
    parameter int unsigned instr_width  = 32,
    parameter int unsigned alu_op_width = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [instr_width-1:0]  instruction,
    input  logic                    imem_valid,
    input  logic                    dmem_ready,
    output logic                    imem_req,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic [alu_op_width-1:0] alu_op,
    output logic                    alu_src_imm,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic                    wb_sel,
    output logic                    regfile_write_enable,
    output logic                    illegal_instr,
    output logic [2:0]              state
);

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMem       = 3'd3,
        StWriteback = 3'd4,
        StTrap      = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ClsR     = 2'd0,
        ClsI     = 2'd1,
        ClsLoad  = 2'd2,
        ClsStore = 2'd3
    } class_e;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluSll  = 4'b0010;
    localparam logic [3:0] AluSlt  = 4'b0011;
    localparam logic [3:0] AluSltu = 4'b0100;
    localparam logic [3:0] AluXor  = 4'b0101;
    localparam logic [3:0] AluSrl  = 4'b0110;
    localparam logic [3:0] AluSra  = 4'b0111;
    localparam logic [3:0] AluOr   = 4'b1000;
    localparam logic [3:0] AluAnd  = 4'b1001;

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpI     = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    localparam logic [6:0] F7Base  = 7'b0000000;
    localparam logic [6:0] F7Alt   = 7'b0100000;

    state_e                  state_q, state_d;
    logic [alu_op_width-1:0] alu_op_q, alu_op_d;
    logic                    alu_src_q, alu_src_d;
    class_e                  class_q, class_d;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic [3:0] f3_op;
    logic [3:0] dec_op;
    logic       dec_imm;
    class_e     dec_class;
    logic       dec_legal;
    logic       unused_instr_bits;

    assign opcode = instruction[6:0];
    assign func3  = instruction[14:12];
    assign func7  = instruction[31:25];
    // Register specifiers and immediates belong to the datapath.
    assign unused_instr_bits = ^{instruction[24:15], instruction[11:7]};

    // Instruction decode from the IR contents.
    always_comb begin
        dec_op    = AluAdd;
        dec_imm   = 1'b0;
        dec_class = ClsR;
        dec_legal = 1'b0;
        f3_op     = AluAdd;

        case (func3)
            3'b001:  f3_op = AluSll;
            3'b010:  f3_op = AluSlt;
            3'b011:  f3_op = AluSltu;
            3'b100:  f3_op = AluXor;
            3'b110:  f3_op = AluOr;
            3'b111:  f3_op = AluAnd;
            default: f3_op = AluAdd;
        endcase

        case (opcode)
            OpR: begin
                dec_class = ClsR;
                dec_legal = 1'b1;
                case (func3)
                    3'b000: begin
                        if (func7 == F7Base)     dec_op = AluAdd;
                        else if (func7 == F7Alt) dec_op = AluSub;
                        else                     dec_legal = 1'b0;
                    end
                    3'b101: begin
                        if (func7 == F7Base)     dec_op = AluSrl;
                        else if (func7 == F7Alt) dec_op = AluSra;
                        else                     dec_legal = 1'b0;
                    end
                    default: begin
                        dec_op = f3_op;
                        if (func7 != F7Base) dec_legal = 1'b0;
                    end
                endcase
            end
            OpI: begin
                dec_class = ClsI;
                dec_imm   = 1'b1;
                dec_legal = 1'b1;
                case (func3)
                    3'b000: dec_op = AluAdd;
                    3'b001: begin
                        dec_op = AluSll;
                        if (func7 != F7Base) dec_legal = 1'b0;
                    end
                    3'b101: begin
                        if (func7 == F7Base)     dec_op = AluSrl;
                        else if (func7 == F7Alt) dec_op = AluSra;
                        else                     dec_legal = 1'b0;
                    end
                    // Upper bits are immediate for the remaining I-type ops.
                    default: dec_op = f3_op;
                endcase
            end
            OpLoad: begin
                dec_class = ClsLoad;
                dec_imm   = 1'b1;
                dec_legal = 1'b1;
            end
            OpStore: begin
                dec_class = ClsStore;
                dec_imm   = 1'b1;
                dec_legal = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state, decode-register capture and output strobes.
    always_comb begin
        state_d              = state_q;
        alu_op_d             = alu_op_q;
        alu_src_d            = alu_src_q;
        class_d              = class_q;
        imem_req             = 1'b0;
        ir_write             = 1'b0;
        pc_write             = 1'b0;
        alu_op               = '0;
        alu_src_imm          = 1'b0;
        dmem_req             = 1'b0;
        dmem_we              = 1'b0;
        wb_sel               = 1'b0;
        regfile_write_enable = 1'b0;
        illegal_instr        = 1'b0;

        case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                alu_op_d  = alu_op_width'(dec_op);
                alu_src_d = dec_imm;
                class_d   = dec_class;
                state_d   = dec_legal ? StExecute : StTrap;
            end
            StExecute: begin
                alu_op      = alu_op_q;
                alu_src_imm = alu_src_q;
                if (class_q == ClsLoad || class_q == ClsStore) state_d = StMem;
                else                                          state_d = StWriteback;
            end
            StMem: begin
                // Address operands held stable for the whole access.
                alu_op      = alu_op_q;
                alu_src_imm = alu_src_q;
                dmem_req    = 1'b1;
                dmem_we     = (class_q == ClsStore);
                if (dmem_ready) state_d = (class_q == ClsStore) ? StFetch : StWriteback;
            end
            StWriteback: begin
                regfile_write_enable = 1'b1;
                wb_sel               = (class_q == ClsLoad);
                state_d              = StFetch;
            end
            StTrap: begin
                illegal_instr = 1'b1;
            end
            default: state_d = StFetch;
        endcase

        // Outputs are forced quiet while reset is held, even mid-handshake.
        if (!rst_n) begin
            imem_req             = 1'b0;
            ir_write             = 1'b0;
            pc_write             = 1'b0;
            alu_op               = '0;
            alu_src_imm          = 1'b0;
            dmem_req             = 1'b0;
            dmem_we              = 1'b0;
            wb_sel               = 1'b0;
            regfile_write_enable = 1'b0;
            illegal_instr        = 1'b0;
        end
    end

    assign state = state_q;

    // State and decode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            alu_op_q  <= '0;
            alu_src_q <= 1'b0;
            class_q   <= ClsR;
        end else begin
            state_q   <= state_d;
            alu_op_q  <= alu_op_d;
            alu_src_q <= alu_src_d;
            class_q   <= class_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and checks strobes against hand-derived expectations.
module tb_multicycle_controller;

    localparam logic [2:0] SFetch = 3'd0, SDecode = 3'd1, SExec = 3'd2;
    localparam logic [2:0] SMem = 3'd3, SWb = 3'd4, STrap = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = '0;
    logic        imem_valid = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, ir_write, pc_write, alu_src_imm, dmem_req, dmem_we;
    logic        wb_sel, regfile_write_enable, illegal_instr;
    logic [3:0]  alu_op;
    logic [2:0]  state;

    int total = 0;
    int bad = 0;

    multicycle_controller #(.instr_width(32), .alu_op_width(4)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .instruction          (instruction),
        .imem_valid           (imem_valid),
        .dmem_ready           (dmem_ready),
        .imem_req             (imem_req),
        .ir_write             (ir_write),
        .pc_write             (pc_write),
        .alu_op               (alu_op),
        .alu_src_imm          (alu_src_imm),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .wb_sel               (wb_sel),
        .regfile_write_enable (regfile_write_enable),
        .illegal_instr        (illegal_instr),
        .state                (state)
    );

    always #5 clk = ~clk;

    wire [15:0] all_out = {imem_req, ir_write, pc_write, alu_op, alu_src_imm, dmem_req,
                           dmem_we, wb_sel, regfile_write_enable, illegal_instr, state};

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        #1;
        total++;
        if (all_out !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0000", all_out);
        end
        step();
        step();
        rst_n = 1'b1;
        #1;
        total++;
        if (state !== SFetch || imem_req !== 1'b1 || ir_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: state=%0d imem_req=%b ir_write=%b want 0/1/0",
                     state, imem_req, ir_write);
        end
    endtask

    // Stays in FETCH for 'waits' cycles, then delivers instr; ends in DECODE.
    task automatic do_fetch(input logic [31:0] instr, input int waits);
        for (int i = 0; i < waits; i++) begin
            imem_valid = 1'b0;
            #1;
            total++;
            if (state !== SFetch || imem_req !== 1'b1 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
                bad++;
                $display("FAIL fetch_wait: state=%0d req=%b irw=%b pcw=%b want 0/1/0/0",
                         state, imem_req, ir_write, pc_write);
            end
            step();
        end
        imem_valid = 1'b1;
        #1;
        total++;
        if (state !== SFetch || imem_req !== 1'b1 || ir_write !== 1'b1 || pc_write !== 1'b1) begin
            bad++;
            $display("FAIL fetch_valid: state=%0d req=%b irw=%b pcw=%b want 0/1/1/1",
                     state, imem_req, ir_write, pc_write);
        end
        step();
        imem_valid = 1'b0;
        instruction = instr;
        #1;
        total++;
        if (state !== SDecode || alu_op !== 4'b0000 || ir_write !== 1'b0) begin
            bad++;
            $display("FAIL decode_state: state=%0d alu_op=%b irw=%b want 1/0000/0",
                     state, alu_op, ir_write);
        end
    endtask

    // R/I instruction: FETCH, DECODE, EXECUTE, WRITEBACK then back to FETCH.
    task automatic do_alu(input string name, input logic [31:0] instr, input int waits,
                          input logic [3:0] exp_op, input logic exp_imm);
        do_fetch(instr, waits);
        step();
        #1;
        total++;
        if (state !== SExec || alu_op !== exp_op || alu_src_imm !== exp_imm || dmem_req !== 1'b0) begin
            bad++;
            $display("FAIL %s_execute: state=%0d alu_op=%b imm=%b dreq=%b want 2/%b/%b/0",
                     name, state, alu_op, alu_src_imm, dmem_req, exp_op, exp_imm);
        end
        step();
        #1;
        total++;
        if (state !== SWb || regfile_write_enable !== 1'b1 || wb_sel !== 1'b0 || alu_op !== 4'b0000) begin
            bad++;
            $display("FAIL %s_writeback: state=%0d rfwe=%b wb_sel=%b alu_op=%b want 4/1/0/0000",
                     name, state, regfile_write_enable, wb_sel, alu_op);
        end
        step();
        #1;
        total++;
        if (state !== SFetch || imem_req !== 1'b1 || regfile_write_enable !== 1'b0) begin
            bad++;
            $display("FAIL %s_return: state=%0d imem_req=%b rfwe=%b want 0/1/0",
                     name, state, imem_req, regfile_write_enable);
        end
    endtask

    task automatic test_reset();
        hold_reset();
    endtask

    task automatic test_add();
        do_alu("add", 32'h002081B3, 1, 4'b0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_alu("sub", 32'h402081B3, 0, 4'b0001, 1'b0);
        do_alu("sra", 32'h4020D1B3, 0, 4'b0111, 1'b0);
    endtask

    task automatic test_i_type();
        do_alu("addi", 32'h00500093, 0, 4'b0000, 1'b1);
        do_alu("srai", 32'h4050D093, 0, 4'b0111, 1'b1);
        // xori with all-ones immediate: upper bits must not be treated as func7.
        do_alu("xori", 32'hFFF0C093, 0, 4'b0101, 1'b1);
    endtask

    task automatic test_load();
        int cycles;
        do_fetch(32'h0000A103, 0);
        cycles = 2;
        step();
        cycles++;
        #1;
        total++;
        if (state !== SExec || alu_op !== 4'b0000 || alu_src_imm !== 1'b1) begin
            bad++;
            $display("FAIL lw_execute: state=%0d alu_op=%b imm=%b want 2/0000/1",
                     state, alu_op, alu_src_imm);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            cycles++;
            dmem_ready = (i == 3);
            #1;
            total++;
            if (state !== SMem || dmem_req !== 1'b1 || dmem_we !== 1'b0 ||
                alu_op !== 4'b0000 || alu_src_imm !== 1'b1) begin
                bad++;
                $display("FAIL lw_mem%0d: state=%0d dreq=%b dwe=%b alu_op=%b imm=%b want 3/1/0/0000/1",
                         i, state, dmem_req, dmem_we, alu_op, alu_src_imm);
            end
        end
        step();
        cycles++;
        dmem_ready = 1'b0;
        #1;
        total++;
        if (state !== SWb || wb_sel !== 1'b1 || regfile_write_enable !== 1'b1 || dmem_req !== 1'b0) begin
            bad++;
            $display("FAIL lw_writeback: state=%0d wb_sel=%b rfwe=%b dreq=%b want 4/1/1/0",
                     state, wb_sel, regfile_write_enable, dmem_req);
        end
        step();
        #1;
        total++;
        if (state !== SFetch || cycles !== 8) begin
            bad++;
            $display("FAIL lw_latency: state=%0d cycles=%0d want 0/8", state, cycles);
        end
    endtask

    task automatic test_store();
        logic saw_rfwe;
        saw_rfwe = 1'b0;
        do_fetch(32'h0020A023, 0);
        step();
        #1;
        saw_rfwe |= regfile_write_enable;
        step();
        dmem_ready = 1'b1;
        #1;
        saw_rfwe |= regfile_write_enable;
        total++;
        if (state !== SMem || dmem_req !== 1'b1 || dmem_we !== 1'b1 || alu_src_imm !== 1'b1) begin
            bad++;
            $display("FAIL sw_mem: state=%0d dreq=%b dwe=%b imm=%b want 3/1/1/1",
                     state, dmem_req, dmem_we, alu_src_imm);
        end
        step();
        dmem_ready = 1'b0;
        #1;
        saw_rfwe |= regfile_write_enable;
        total++;
        if (state !== SFetch || imem_req !== 1'b1 || saw_rfwe !== 1'b0) begin
            bad++;
            $display("FAIL sw_return: state=%0d imem_req=%b saw_rfwe=%b want 0/1/0",
                     state, imem_req, saw_rfwe);
        end
    endtask

    task automatic run_trap(input string name, input logic [31:0] instr);
        do_fetch(instr, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            imem_valid = 1'b1;  // must be ignored in TRAP
            dmem_ready = 1'b1;
            #1;
            total++;
            if (state !== STrap || illegal_instr !== 1'b1 || imem_req !== 1'b0 ||
                ir_write !== 1'b0 || dmem_req !== 1'b0 || regfile_write_enable !== 1'b0) begin
                bad++;
                $display("FAIL %s_trap%0d: state=%0d ill=%b req=%b irw=%b dreq=%b rfwe=%b want 5/1/0/0/0/0",
                         name, i, state, illegal_instr, imem_req, ir_write, dmem_req,
                         regfile_write_enable);
            end
        end
        hold_reset();
    endtask

    task automatic test_illegal();
        run_trap("bad_func7", 32'h202081B3);
        run_trap("bad_opcode", 32'h0000007F);
    endtask

    task automatic test_reset_mid_store();
        do_fetch(32'h0020A023, 0);
        step();
        step();
        dmem_ready = 1'b0;
        step();
        #1;
        total++;
        if (state !== SMem || dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
            bad++;
            $display("FAIL midrst_wait: state=%0d dreq=%b dwe=%b want 3/1/1", state, dmem_req, dmem_we);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || state !== SFetch || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL midrst_drop: dreq=%b dwe=%b state=%0d imem_req=%b want 0/0/0/0",
                     dmem_req, dmem_we, state, imem_req);
        end
        hold_reset();
        dmem_ready = 1'b1;
        #1;
        total++;
        if (dmem_we !== 1'b0 || dmem_req !== 1'b0) begin
            bad++;
            $display("FAIL midrst_nowrite: dreq=%b dwe=%b want 0/0", dmem_req, dmem_we);
        end
        dmem_ready = 1'b0;
    endtask

    initial begin
        step();
        test_reset();
        test_add();
        test_back_to_back();
        test_i_type();
        test_load();
        test_store();
        test_illegal();
        test_reset_mid_store();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
